// File: rtl/move_pkg.sv
// Shared types and PS/2 scan-code constants for the arrow-key move command controller.
package move_pkg;

    typedef enum logic [1:0] {
        MOVE_NEG  = 2'd0,
        MOVE_POS  = 2'd1,
        MOVE_STOP = 2'd2
    } move_t;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } parse_state_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Key masks use the keysHeld bit order {right, left, down, up}.
    function automatic logic [3:0] arrow_key(input logic [7:0] code);
        case (code)
            SC_UP:    return 4'b0001;
            SC_DOWN:  return 4'b0010;
            SC_LEFT:  return 4'b0100;
            SC_RIGHT: return 4'b1000;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] wasd_key(input logic [7:0] code);
        case (code)
            SC_W:    return 4'b0001;
            SC_S:    return 4'b0010;
            SC_A:    return 4'b0100;
            SC_D:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/move_cmd_ctrl_axis_arbiter.sv
// Resolves one axis from its two held keys; when both are held the last-pressed key wins.
module axis_arbiter
    import move_pkg::*;
(
    input  logic  neg_held,
    input  logic  pos_held,
    input  logic  last_pos,
    output move_t move
);

    always_comb begin
        move = MOVE_STOP;
        if (neg_held && pos_held)
            move = last_pos ? MOVE_POS : MOVE_NEG;
        else if (pos_held)
            move = MOVE_POS;
        else if (neg_held)
            move = MOVE_NEG;
    end

endmodule

// File: rtl/move_cmd_ctrl.sv
// PS/2 scan-code parser producing frame-latched per-axis move commands from the arrow keys.
// Define WASD_EN to also accept the non-extended W/A/S/D codes as aliases of the arrows.
//
// state   | meaning
// IDLE    | waiting for a prefix byte
// EXT     | E0 seen, expecting arrow make code or F0
// BRK     | F0 seen without E0, next byte is a non-extended break
// EXT_BRK | E0 F0 seen, expecting arrow break code
module move_cmd_ctrl
    import move_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 50000,
    localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scanCode,
    input  logic       scanValid,
    input  logic       frameTick,
    output logic [1:0] moveX,
    output logic [1:0] moveY,
    output logic [3:0] keysHeld,
    output logic       protoErr
);

    parse_state_t     state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       held_arrow;
    logic             last_x;
    logic             last_y;
    logic [3:0]       arrow_mask;
    logic [3:0]       make_a;
    logic [3:0]       brk_a;
    logic [3:0]       make_all;
    move_t            pend_x;
    move_t            pend_y;

    assign arrow_mask = arrow_key(scanCode);

`ifdef WASD_EN
    logic [3:0] held_wasd;
    logic [3:0] wasd_mask;
    logic [3:0] make_w;
    logic [3:0] brk_w;

    assign wasd_mask = wasd_key(scanCode);
    assign make_w    = (scanValid && state == IDLE) ? wasd_mask : 4'b0000;
    assign brk_w     = (scanValid && state == BRK)  ? wasd_mask : 4'b0000;
    assign make_all  = make_a | make_w;
    assign keysHeld  = held_arrow | held_wasd;

    always_ff @(posedge clk) begin
        if (reset)
            held_wasd <= 4'b0000;
        else
            held_wasd <= (held_wasd | make_w) & ~brk_w;
    end
`else
    assign make_all = make_a;
    assign keysHeld = held_arrow;
`endif

    assign make_a = (scanValid && state == EXT)     ? arrow_mask : 4'b0000;
    assign brk_a  = (scanValid && state == EXT_BRK) ? arrow_mask : 4'b0000;

    axis_arbiter u_arb_x (
        .neg_held (keysHeld[2]),
        .pos_held (keysHeld[3]),
        .last_pos (last_x),
        .move     (pend_x)
    );

    axis_arbiter u_arb_y (
        .neg_held (keysHeld[0]),
        .pos_held (keysHeld[1]),
        .last_pos (last_y),
        .move     (pend_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            held_arrow <= 4'b0000;
            last_x     <= 1'b0;
            last_y     <= 1'b0;
            moveX      <= MOVE_STOP;
            moveY      <= MOVE_STOP;
            protoErr   <= 1'b0;
        end else begin
            protoErr   <= 1'b0;
            held_arrow <= (held_arrow | make_a) & ~brk_a;

            if (make_all[3])
                last_x <= 1'b1;
            else if (make_all[2])
                last_x <= 1'b0;
            if (make_all[1])
                last_y <= 1'b1;
            else if (make_all[0])
                last_y <= 1'b0;

            // Pending values come from pre-byte held state, so a coincident byte waits a frame.
            if (frameTick) begin
                moveX <= pend_x;
                moveY <= pend_y;
            end

            if (scanValid) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (scanCode == SC_E0)
                            state <= EXT;
                        else if (scanCode == SC_F0)
                            state <= BRK;
                    end
                    EXT: begin
                        if (scanCode == SC_F0)
                            state <= EXT_BRK;
                        else if (scanCode != SC_E0)
                            state <= IDLE;
                    end
                    BRK: begin
                        state <= IDLE;
                        if (scanCode == SC_E0 || scanCode == SC_F0)
                            protoErr <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    tmo_cnt  <= '0;
                    protoErr <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_move_cmd_ctrl.sv
// Directed bench for move_cmd_ctrl with a short timeout; WASD checks follow the WASD_EN build.
module tb_move_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       frameTick;
    logic [1:0] moveX;
    logic [1:0] moveY;
    logic [3:0] keysHeld;
    logic       protoErr;

    int checks = 0;
    int errors = 0;

    move_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .scanCode  (scanCode),
        .scanValid (scanValid),
        .frameTick (frameTick),
        .moveX     (moveX),
        .moveY     (moveY),
        .keysHeld  (keysHeld),
        .protoErr  (protoErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scanCode  = b;
        scanValid = 1'b1;
        @(negedge clk);
        scanValid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        scanCode  = 8'h00;
        scanValid = 1'b0;
        frameTick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_movex", {6'd0, moveX}, 8'd2);
        chk("rst_movey", {6'd0, moveY}, 8'd2);
        chk("rst_keys", {4'd0, keysHeld}, 8'h00);
        chk("rst_err", {7'd0, protoErr}, 8'd0);

        // Left make; command waits for the frame tick
        send(8'hE0); send(8'h6B);
        chk("left_keys", {4'd0, keysHeld}, 8'h04);
        chk("left_pretick", {6'd0, moveX}, 8'd2);
        tick();
        chk("left_movex", {6'd0, moveX}, 8'd0);
        chk("left_movey", {6'd0, moveY}, 8'd2);

        // Right pressed while left held -> right wins; release order back to left then stop
        send(8'hE0); send(8'h74);
        chk("lr_keys", {4'd0, keysHeld}, 8'h0C);
        tick();
        chk("lr_movex", {6'd0, moveX}, 8'd1);
        send(8'hE0); send(8'hF0); send(8'h74);
        tick();
        chk("rrel_movex", {6'd0, moveX}, 8'd0);
        chk("rrel_keys", {4'd0, keysHeld}, 8'h04);
        send(8'hE0); send(8'hF0); send(8'h6B);
        tick();
        chk("lrel_movex", {6'd0, moveX}, 8'd2);
        chk("lrel_keys", {4'd0, keysHeld}, 8'h00);

        // Diagonal
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
        tick();
        chk("diag_movey", {6'd0, moveY}, 8'd0);
        chk("diag_movex", {6'd0, moveX}, 8'd0);
        send(8'hE0); send(8'hF0); send(8'h75);
        tick();
        chk("uprel_movey", {6'd0, moveY}, 8'd2);
        chk("uprel_movex", {6'd0, moveX}, 8'd0);

        // Typematic repeat of left re-claims the axis from right
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
        tick();
        chk("repeat_movex", {6'd0, moveX}, 8'd0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        tick();
        chk("repeat_rel_movex", {6'd0, moveX}, 8'd1);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("repeat_keys", {4'd0, keysHeld}, 8'h00);

        // Break of a key not held is silently ignored
        send(8'hE0); send(8'hF0); send(8'h72);
        chk("nohold_brk_keys", {4'd0, keysHeld}, 8'h00);
        chk("nohold_brk_err", {7'd0, protoErr}, 8'd0);

        // Prefix timeout: exactly one protoErr pulse, parser back in IDLE
        send(8'hE0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (protoErr) pulses++;
        end
        chk("tmo_pulses", pulses[7:0], 8'd1);
        send(8'h74);
        chk("tmo_after_keys", {4'd0, keysHeld}, 8'h00);

        // F0 followed by a prefix byte is illegal
        send(8'hF0); send(8'hE0);
        chk("brk_prefix_err", {7'd0, protoErr}, 8'd1);
        @(negedge clk);
        chk("brk_prefix_err_clr", {7'd0, protoErr}, 8'd0);
        send(8'h74);
        chk("brk_prefix_keys", {4'd0, keysHeld}, 8'h00);

        // Down make coincident with frameTick: that tick still latches stop
        send(8'hE0);
        @(negedge clk);
        scanCode  = 8'h72;
        scanValid = 1'b1;
        frameTick = 1'b1;
        @(negedge clk);
        scanValid = 1'b0;
        frameTick = 1'b0;
        chk("coinc_movey", {6'd0, moveY}, 8'd2);
        chk("coinc_keys", {4'd0, keysHeld}, 8'h02);
        tick();
        chk("coinc_next_movey", {6'd0, moveY}, 8'd1);

        // Reset while keys held, with a half-received prefix pending
        send(8'hE0); send(8'h6B);
        tick();
        chk("prerst_movex", {6'd0, moveX}, 8'd0);
        send(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_movex", {6'd0, moveX}, 8'd2);
        chk("midrst_movey", {6'd0, moveY}, 8'd2);
        chk("midrst_keys", {4'd0, keysHeld}, 8'h00);
        send(8'h72);
        chk("postrst_nomake", {4'd0, keysHeld}, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h72);
        tick();
        chk("postrst_brk_movey", {6'd0, moveY}, 8'd2);
        chk("postrst_brk_keys", {4'd0, keysHeld}, 8'h00);

        // WASD 'A'
        send(8'h1C);
        tick();
`ifdef WASD_EN
        chk("wasd_a_movex", {6'd0, moveX}, 8'd0);
        chk("wasd_a_keys", {4'd0, keysHeld}, 8'h04);
`else
        chk("wasd_a_movex", {6'd0, moveX}, 8'd2);
        chk("wasd_a_keys", {4'd0, keysHeld}, 8'h00);
`endif
        send(8'hF0); send(8'h1C);
        chk("wasd_brk_err", {7'd0, protoErr}, 8'd0);
        tick();
        chk("wasd_rel_movex", {6'd0, moveX}, 8'd2);
        chk("wasd_rel_keys", {4'd0, keysHeld}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
